// File: rtl/display_scan_driver_pkg.sv
// Shared definitions for the scanned seven-segment display driver:
// FSM state encoding, active-low segment patterns and small helpers.
package display_scan_driver_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Active-low, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // True when ndigits decimal digits can hold the largest nbits-wide value.
    function automatic bit digits_fit(input int nbits, input int ndigits);
        longint p10;
        p10 = 1;
        for (int i = 0; i < ndigits; i++) begin
            p10 = p10 * 10;
        end
        return p10 > ((longint'(1) << nbits) - 1);
    endfunction

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/display_scan_driver_seven_seg_decoder.sv
// Purely combinational BCD digit to active-low seven-segment pattern.
// Codes above 9 never occur in practice and are shown as a blank digit.
module seven_seg_decoder
    import display_scan_driver_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_driver.sv
// Binary-to-BCD converter (sequential double dabble, one shift per cycle)
// feeding a double-buffered, time-multiplexed seven-segment digit scanner.
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int p_nbits    = 5,
    parameter int p_ndigits  = 2,
    parameter int p_scan_div = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [p_nbits-1:0]   in_data,
    input  logic                 blank_lz,
    output logic                 conv_done,
    output logic [6:0]           seg,
    output logic [p_ndigits-1:0] digit_en
);

    localparam int BCD_W = 4 * p_ndigits;
    localparam int CNT_W = $clog2(p_nbits + 1);
    localparam int DIV_W = (p_scan_div > 1) ? $clog2(p_scan_div) : 1;
    localparam int IDX_W = (p_ndigits > 1) ? $clog2(p_ndigits) : 1;

    if (!digits_fit(p_nbits, p_ndigits)) begin : g_bad_ndigits
        $error("display_scan_driver: p_ndigits too small for p_nbits");
    end
    if (p_scan_div < 1) begin : g_bad_scan_div
        $error("display_scan_driver: p_scan_div must be at least 1");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_last;

    logic [p_nbits-1:0]   r_bin;
    logic [BCD_W-1:0]     r_bcd;
    logic [CNT_W-1:0]     r_cnt;
    logic [BCD_W-1:0]     r_display;
    logic                 r_conv_done;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BCD_W+p_nbits-1:0] w_shifted;

    logic [DIV_W-1:0]     r_div;
    logic [IDX_W-1:0]     r_idx;
    logic [p_ndigits-1:0] w_blank;
    logic                 w_upper_zero;
    logic [3:0]           w_nibble;
    logic [6:0]           w_dec_seg;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        in_rdy       = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    w_load       = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < p_ndigits; i++) begin
            w_bcd_adj[4*i +: 4] = dabble_adjust(r_bcd[4*i +: 4]);
        end
    end

    assign w_shifted = {w_bcd_adj, r_bin} << 1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_display   <= '0;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= w_last;
            if (w_load) begin
                r_bin <= in_data;
                r_bcd <= '0;
                r_cnt <= CNT_W'(p_nbits);
            end else if (w_shift) begin
                r_bcd <= w_shifted[BCD_W+p_nbits-1 -: BCD_W];
                r_bin <= w_shifted[p_nbits-1:0];
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) r_display <= w_shifted[BCD_W+p_nbits-1 -: BCD_W];
            end
        end
    end

    assign conv_done = r_conv_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(p_scan_div - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(p_ndigits - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // A digit is blanked only if it and every more significant digit are zero.
    always_comb begin
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int i = p_ndigits - 1; i >= 1; i--) begin
            w_upper_zero = w_upper_zero & (r_display[4*i +: 4] == 4'd0);
            w_blank[i]   = blank_lz & w_upper_zero;
        end
    end

    assign w_nibble = r_display[4*int'(r_idx) +: 4];

    seven_seg_decoder u_dec (
        .i_bcd (w_nibble),
        .o_seg (w_dec_seg)
    );

    assign digit_en = p_ndigits'(1) << r_idx;
    assign seg      = w_blank[r_idx] ? SEG_BLANK : w_dec_seg;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench: two configurations of display_scan_driver compared every
// cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_display_scan_driver;

    localparam int NB_A = 5,  ND_A = 2, SD_A = 4;
    localparam int NB_B = 10, ND_B = 4, SD_B = 1;

    logic clk;
    logic rst;

    logic            a_in_val, a_in_rdy, a_blank, a_done;
    logic [NB_A-1:0] a_in_data;
    logic [6:0]      a_seg;
    logic [ND_A-1:0] a_en;

    logic            b_in_val, b_in_rdy, b_blank, b_done;
    logic [NB_B-1:0] b_in_data;
    logic [6:0]      b_seg;
    logic [ND_B-1:0] b_en;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan_driver #(.p_nbits(NB_A), .p_ndigits(ND_A), .p_scan_div(SD_A)) dut_a (
        .clk(clk), .rst(rst), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_data(a_in_data),
        .blank_lz(a_blank), .conv_done(a_done), .seg(a_seg), .digit_en(a_en)
    );

    display_scan_driver #(.p_nbits(NB_B), .p_ndigits(ND_B), .p_scan_div(SD_B)) dut_b (
        .clk(clk), .rst(rst), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_data(b_in_data),
        .blank_lz(b_blank), .conv_done(b_done), .seg(b_seg), .digit_en(b_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int busy;     // shift cycles still to go; 0 = ready
        int pending;  // value being converted
        int shown;    // value on the display
        int tick;     // clock edges since reset
        bit done;
    } mdl_t;

    mdl_t ma, mb;
    bit   m_ok = 1'b0;

    function automatic mdl_t mdl_step(mdl_t m, bit r, bit v, int d, int nb);
        mdl_t n;
        n = m;
        n.done = 1'b0;
        if (r) begin
            n.busy  = 0;
            n.shown = 0;
            n.tick  = 0;
        end else begin
            n.tick = m.tick + 1;
            if (m.busy > 0) begin
                n.busy = m.busy - 1;
                if (n.busy == 0) begin
                    n.shown = m.pending;
                    n.done  = 1'b1;
                end
            end else if (v) begin
                n.pending = d;
                n.busy    = nb;
            end
        end
        return n;
    endfunction

    function automatic int pow10(input int e);
        int p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] digit_pattern(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int shown, input int idx, input bit blank);
        if (blank && idx >= 1 && shown < pow10(idx)) return 7'b1111111;
        return digit_pattern((shown / pow10(idx)) % 10);
    endfunction

    always @(posedge clk) begin
        ma   = mdl_step(ma, rst, a_in_val, int'(a_in_data), NB_A);
        mb   = mdl_step(mb, rst, b_in_val, int'(b_in_data), NB_B);
        m_ok = 1'b1;
    end

    // Single compare process: all outputs of both instances, every cycle.
    always @(negedge clk) begin
        int ia, ib;
        if (m_ok) begin
            ia = (ma.tick / SD_A) % ND_A;
            ib = (mb.tick / SD_B) % ND_B;
            check("a_rdy",  32'(a_in_rdy), 32'(ma.busy == 0));
            check("a_done", 32'(a_done),   32'(ma.done));
            check("a_en",   32'(a_en),     32'(1) << ia);
            check("a_seg",  32'(a_seg),    32'(exp_seg(ma.shown, ia, a_blank)));
            check("b_rdy",  32'(b_in_rdy), 32'(mb.busy == 0));
            check("b_done", 32'(b_done),   32'(mb.done));
            check("b_en",   32'(b_en),     32'(1) << ib);
            check("b_seg",  32'(b_seg),    32'(exp_seg(mb.shown, ib, b_blank)));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 2 time units after the falling edge, clear of both sampling points.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_done_a(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!a_done && n < 40) begin
            step();
            n++;
        end
        check(name, 32'(n), 32'(exp_lat));
    endtask

    task automatic wait_digit_a(input int idx);
        int n;
        n = 0;
        while (a_en !== (ND_A'(1) << idx) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("a_digit_timeout", 32'(a_en), 32'(1) << idx);
    endtask

    initial begin
        logic [ND_B-1:0] prev_en;
        logic [6:0]      lit;
        int n;

        rst = 1'b1;
        a_in_val = 1'b0; a_in_data = '0; a_blank = 1'b0;
        b_in_val = 1'b0; b_in_data = '0; b_blank = 1'b0;
        step();
        step();

        // Reset state and idle scan
        check("rst_seg", 32'(a_seg), 32'(7'b1000000));
        check("rst_en",  32'(a_en), 32'(2'b01));
        check("rst_rdy", 32'(a_in_rdy), 32'(1));
        check("rst_done", 32'(a_done), 32'(0));
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("idle_en", 32'(a_en), (j < 4) ? 32'(2'b01) : 32'(2'b10));
            a_blank = 1'b0;
            #1 check("idle_seg_nb", 32'(a_seg), 32'(7'b1000000));
            a_blank = 1'b1;
            #1 check("idle_seg_bl", 32'(a_seg), (j < 4) ? 32'(7'b1000000) : 32'(7'b1111111));
            a_blank = 1'b0;
            step();
        end

        // 17 -> "17", five-cycle latency
        a_in_val = 1'b1; a_in_data = 5'd17;
        step();
        a_in_val = 1'b0;
        check("busy17", 32'(a_in_rdy), 32'(0));
        wait_done_a("lat17", 5);
        wait_digit_a(0);
        check("seg17_d0", 32'(a_seg), 32'(7'b1111000));
        wait_digit_a(1);
        check("seg17_d1", 32'(a_seg), 32'(7'b1111001));

        // 31 then 0 back-to-back with in_val held
        step();
        a_in_val = 1'b1; a_in_data = 5'd31;
        step();
        a_in_data = 5'd0;
        wait_done_a("lat31", 5);
        check("rdy_at_done", 32'(a_in_rdy), 32'(1));
        check("seg31", 32'(a_seg), (a_en == 2'b01) ? 32'(7'b1111001) : 32'(7'b0110000));
        step();
        a_in_val = 1'b0;
        check("busy0", 32'(a_in_rdy), 32'(0));
        wait_done_a("lat0", 5);
        a_blank = 1'b1;
        wait_digit_a(1);
        check("zero_tens_blank", 32'(a_seg), 32'(7'b1111111));
        wait_digit_a(0);
        check("zero_ones", 32'(a_seg), 32'(7'b1000000));
        a_blank = 1'b0;

        // 9 with a competing 22 offered during CONV
        a_in_val = 1'b1; a_in_data = 5'd9;
        step();
        a_in_data = 5'd22;
        step(); step(); step();
        a_in_val = 1'b0;
        wait_done_a("lat9", 2);
        wait_digit_a(1);
        check("seg09_d1", 32'(a_seg), 32'(7'b1000000));
        wait_digit_a(0);
        check("seg09_d0", 32'(a_seg), 32'(7'b0010000));

        // Reset three cycles into converting 25
        a_in_val = 1'b1; a_in_data = 5'd25;
        step();
        a_in_val = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_seg", 32'(a_seg), 32'(7'b1000000));
        check("abort_rdy", 32'(a_in_rdy), 32'(1));
        check("abort_en",  32'(a_en), 32'(2'b01));
        for (int k = 0; k < 8; k++) begin
            check("abort_nodone", 32'(a_done), 32'(0));
            step();
        end

        // Wide configuration: 1023 over four digits, scan every cycle
        b_blank = 1'b1;
        b_in_val = 1'b1; b_in_data = 10'd1023;
        step();
        b_in_val = 1'b0;
        n = 0;
        while (!b_done && n < 40) begin
            step();
            n++;
        end
        check("lat1023", 32'(n), 32'(10));
        for (int k = 0; k < 5; k++) begin
            prev_en = b_en;
            step();
            check("b_rotate", 32'(b_en), 32'({prev_en[ND_B-2:0], prev_en[ND_B-1]}));
            case (b_en)
                4'b0001: lit = 7'b0110000;
                4'b0010: lit = 7'b0100100;
                4'b0100: lit = 7'b1000000;
                default: lit = 7'b1111001;
            endcase
            check("b_seg1023", 32'(b_seg), 32'(lit));
        end

        // Randomised traffic on both instances, occasional reset
        for (int k = 0; k < 3000; k++) begin
            step();
            rst       = ($urandom_range(0, 299) == 0);
            a_in_val  = ($urandom_range(0, 2) == 0);
            a_in_data = NB_A'($urandom_range(0, 31));
            a_blank   = 1'($urandom_range(0, 1));
            b_in_val  = ($urandom_range(0, 3) == 0);
            b_in_data = NB_B'($urandom_range(0, 1023));
            b_blank   = 1'($urandom_range(0, 1));
        end
        rst = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
